kbd_scan_ctrl: RTL and testbench

//  Sequences the scancode->ASCII lookup RAM for the PS/2 keyboard path.

---
 rtl/kbd_scan_ctrl.sv | 85 ++++++++
 tb/tb_kbd_scan_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/kbd_scan_ctrl.sv
// kbd_scan_ctrl: PS/2 set-2 scancode decoder that sequences the ASCII lookup RAM and queues characters in a FIFO
module kbd_scan_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  output logic       scan_ready,
  output logic [7:0] lut_addr,
  output logic [1:0] lut_state,
  input  logic [7:0] lut_data,
  output logic       ascii_valid,
  output logic [7:0] ascii_data,
  input  logic       ascii_ready,
  output logic       shift_held,
  output logic       caps_led,
  output logic       overflow
);
  typedef enum logic [1:0] {IDLE, REQ, CAP} state_t;
  state_t state, state_nx;
  logic brk, ext, lshift, rshift, caps, caps_down;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic accept, special, lookup, push, pop, full, wr;
  assign scan_ready  = state == IDLE;
  assign accept      = scan_valid & scan_ready;
  assign special     = scan_code == 8'hf0 || scan_code == 8'he0 || scan_code == 8'h12 ||
                       scan_code == 8'h59 || scan_code == 8'h58;
  assign lookup      = accept & ~brk & ~ext & ~special;
  assign push        = state == CAP && lut_data != 8'h00;
  assign ascii_valid = count != '0;
  assign full        = count == (AW+1)'(DEPTH);
  assign pop         = ascii_valid & ascii_ready;
  assign wr          = push & (~full | pop);
  assign ascii_data  = mem[rd_ptr];
  assign shift_held  = lshift | rshift;
  assign caps_led    = caps;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (lookup ? REQ : IDLE) : state == REQ ? CAP : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {brk, ext, lshift, rshift, caps, caps_down, overflow} <= '0;
      lut_addr  <= '0;
      lut_state <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      if ((scan_valid & ~scan_ready) | (push & full & ~pop)) overflow <= 1'b1;
      if (accept) begin
        if (scan_code == 8'hf0) brk <= 1'b1;
        else if (scan_code == 8'he0) ext <= 1'b1;
        else begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (!ext) begin
            if (scan_code == 8'h12) lshift <= ~brk;
            else if (scan_code == 8'h59) rshift <= ~brk;
            else if (scan_code == 8'h58) begin
              caps_down <= ~brk;
              // typematic repeats keep caps_down set, so only the first make toggles
              if (!brk && !caps_down) caps <= ~caps;
            end else if (!brk) begin
              lut_addr  <= scan_code;
              lut_state <= {caps, shift_held};
            end
          end
        end
      end
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= lut_data;
endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// tb_kbd_scan_ctrl: table-driven check of the scancode controller against a behavioural lookup RAM
module tb_kbd_scan_ctrl;
  logic clk = 0, rst = 1;
  logic scan_valid = 0, ascii_ready = 0;
  logic [7:0] scan_code = 0, lut_data = 0;
  logic scan_ready, ascii_valid, shift_held, caps_led, overflow;
  logic [7:0] lut_addr, ascii_data;
  logic [1:0] lut_state;
  int checks = 0, errors = 0;

  kbd_scan_ctrl dut (
    .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_code(scan_code),
    .scan_ready(scan_ready), .lut_addr(lut_addr), .lut_state(lut_state),
    .lut_data(lut_data), .ascii_valid(ascii_valid), .ascii_data(ascii_data),
    .ascii_ready(ascii_ready), .shift_held(shift_held), .caps_led(caps_led),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram(input logic [1:0] s, input logic [7:0] a);
    logic [7:0] lc;
    case (a)
      8'h1c: lc = 8'h61;  8'h32: lc = 8'h62;  8'h21: lc = 8'h63;  8'h23: lc = 8'h64;
      8'h24: lc = 8'h65;  8'h2b: lc = 8'h66;  8'h34: lc = 8'h67;  8'h33: lc = 8'h68;
      8'h43: lc = 8'h69;  8'h3b: lc = 8'h6a;  default: lc = 8'h00;
    endcase
    return lc == 8'h00 ? 8'h00 : (s == 2'd1 || s == 2'd2) ? lc - 8'h20 : lc;
  endfunction

  always @(posedge clk) lut_data <= ram(lut_state, lut_addr);

  typedef struct {
    logic [7:0] code;
    logic       lk;
    logic [1:0] st;
    logic [7:0] ch;
    logic       sh;
    logic       cp;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t mk(input logic [7:0] code, input logic lk, input logic [1:0] st,
                              input logic [7:0] ch, input logic sh, input logic cp);
    vec_t v;
    v.code = code; v.lk = lk; v.st = st; v.ch = ch; v.sh = sh; v.cp = cp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; scan_valid = 0; ascii_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic send(input logic [7:0] c);
    int n = 0;
    @(negedge clk);
    while (!scan_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!scan_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout got=busy expected=idle code=%h", c);
    end
    scan_valid = 1; scan_code = c;
    @(posedge clk);
    #1 scan_valid = 0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    ascii_ready = 1;
    @(posedge clk);
    #1 ascii_ready = 0;
    chk("pop_empty", 8'(ascii_valid), 8'd0);
  endtask

  initial begin
    logic [7:0] keys [9];
    logic [7:0] drain [8];
    keys  = '{8'h1c, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2b, 8'h34, 8'h33, 8'h43};
    drain = '{8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h6a};
    vq.push_back(mk(8'h1c, 1, 0, 8'h61, 0, 0));
    vq.push_back(mk(8'h12, 0, 0, 8'h00, 1, 0));
    vq.push_back(mk(8'h1c, 1, 1, 8'h41, 1, 0));
    vq.push_back(mk(8'hf0, 0, 0, 8'h00, 1, 0));
    vq.push_back(mk(8'h1c, 0, 0, 8'h00, 1, 0));
    vq.push_back(mk(8'hf0, 0, 0, 8'h00, 1, 0));
    vq.push_back(mk(8'h12, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(8'he0, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(8'h75, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(8'he0, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(8'hf0, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(8'h75, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(8'he0, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(8'h12, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(8'h1c, 1, 0, 8'h61, 0, 0));
    vq.push_back(mk(8'h58, 0, 0, 8'h00, 0, 1));
    vq.push_back(mk(8'h58, 0, 0, 8'h00, 0, 1));
    vq.push_back(mk(8'h58, 0, 0, 8'h00, 0, 1));
    vq.push_back(mk(8'hf0, 0, 0, 8'h00, 0, 1));
    vq.push_back(mk(8'h58, 0, 0, 8'h00, 0, 1));
    vq.push_back(mk(8'h1c, 1, 2, 8'h41, 0, 1));
    vq.push_back(mk(8'h12, 0, 0, 8'h00, 1, 1));
    vq.push_back(mk(8'h1c, 1, 3, 8'h61, 1, 1));
    vq.push_back(mk(8'hf0, 0, 0, 8'h00, 1, 1));
    vq.push_back(mk(8'h12, 0, 0, 8'h00, 0, 1));
    vq.push_back(mk(8'h58, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(8'hf0, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(8'h58, 0, 0, 8'h00, 0, 0));
    vq.push_back(mk(8'h76, 1, 0, 8'h00, 0, 0));

    do_reset();
    chk("rst_ready", 8'(scan_ready), 8'd1);
    chk("rst_valid", 8'(ascii_valid), 8'd0);
    chk("rst_addr", lut_addr, 8'h00);
    chk("rst_state", 8'(lut_state), 8'd0);
    chk("rst_shift", 8'(shift_held), 8'd0);
    chk("rst_caps", 8'(caps_led), 8'd0);
    chk("rst_ovf", 8'(overflow), 8'd0);

    foreach (vq[i]) begin
      send(vq[i].code);
      chk($sformatf("v%0d_shift", i), 8'(shift_held), 8'(vq[i].sh));
      chk($sformatf("v%0d_caps", i), 8'(caps_led), 8'(vq[i].cp));
      chk($sformatf("v%0d_lookup", i), 8'(!scan_ready), 8'(vq[i].lk));
      if (vq[i].lk) begin
        chk($sformatf("v%0d_addr", i), lut_addr, vq[i].code);
        chk($sformatf("v%0d_state", i), 8'(lut_state), 8'(vq[i].st));
        @(posedge clk); #1;
        chk($sformatf("v%0d_addr_hold", i), lut_addr, vq[i].code);
        chk($sformatf("v%0d_early", i), 8'(ascii_valid), 8'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_idle", i), 8'(scan_ready), 8'd1);
        chk($sformatf("v%0d_valid", i), 8'(ascii_valid), 8'(vq[i].ch != 8'h00));
        if (vq[i].ch != 8'h00) begin
          chk($sformatf("v%0d_char", i), ascii_data, vq[i].ch);
          pop_one();
        end
      end
    end
    chk("tbl_ovf", 8'(overflow), 8'd0);

    do_reset();
    send(8'h1c);
    @(negedge clk);
    scan_valid = 1; scan_code = 8'h12;
    @(posedge clk);
    #1 scan_valid = 0;
    chk("drop_ovf", 8'(overflow), 8'd1);
    chk("drop_shift", 8'(shift_held), 8'd0);
    repeat (3) @(posedge clk);

    do_reset();
    chk("rst2_ovf", 8'(overflow), 8'd0);
    foreach (keys[i]) send(keys[i]);
    repeat (2) @(posedge clk);
    #1;
    chk("full_ovf", 8'(overflow), 8'd1);
    chk("full_head", ascii_data, 8'h61);
    send(8'h3b);
    @(posedge clk); #1;
    @(negedge clk);
    ascii_ready = 1;
    chk("full_head2", ascii_data, 8'h61);
    @(posedge clk); #1;
    foreach (drain[i]) begin
      chk($sformatf("drain%0d_valid", i), 8'(ascii_valid), 8'd1);
      chk($sformatf("drain%0d", i), ascii_data, drain[i]);
      @(posedge clk); #1;
    end
    chk("drain_empty", 8'(ascii_valid), 8'd0);
    ascii_ready = 0;

    do_reset();
    send(8'h58);
    chk("mid_caps_on", 8'(caps_led), 8'd1);
    send(8'h1c);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 0;
    chk("mid_valid", 8'(ascii_valid), 8'd0);
    chk("mid_caps", 8'(caps_led), 8'd0);
    chk("mid_ready", 8'(scan_ready), 8'd1);
    chk("mid_addr", lut_addr, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_nochar", 8'(ascii_valid), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
